acq_frame_sequencer: RTL
========================

# acq_frame_sequencer

Consumer of the time-manager outputs: it turns the frame-boundary and acquisition-start pulses into one request/acknowledge conversion transaction per sample tick towards the ADC driver. It counts completed samples per 25 ms frame and reports a per-frame summary. It flags overrun, timeout and sample-count faults with sticky error bits. It sits between the time manager and the ADC interface in the `sys_clk_i` domain; all inputs are already synchronous to `sys_clk_i`, so it has no input synchronizers.

## Interface
- SAMPLES_PER_FRAME, 25, expected completed conversions per frame (1..255)
- ACQ_TIMEOUT, 50_000, max cycles from request issue to `acq_done_i` (2..2^20)
- sys_clk_i  in  1  system clock, 100 MHz
- rst_n_i  in  1  reset, asynchronous, active-low
- time_period_0_10ms_i  in  1  level; high = resync window
- frame_pulse_i  in  1  one-cycle frame boundary (every 25 ms)
- acq_start_pulse_i  in  1  one-cycle sample tick
- acq_ack_i  in  1  ADC driver accepted request
- acq_done_i  in  1  one-cycle conversion complete
- err_clr_i  in  1  one-cycle clear of all sticky errors
- acq_req_o  out  1  conversion request, held until ack
- sample_idx_o  out  8  in-frame index of last issued request
- frame_cnt_o  out  16  completed frames since resync, wraps
- frame_done_o  out  1  one-cycle pulse, frame summary valid
- frame_sample_cnt_o  out  8  completed samples in last closed frame
- err_overrun_o  out  1  sticky: start tick dropped while busy
- err_timeout_o  out  1  sticky: conversion not done within ACQ_TIMEOUT
- err_count_o  out  1  sticky: closed frame count != SAMPLES_PER_FRAME

## Operation
- States: S_RESYNC, S_WAIT, S_REQ, S_CONV. Reset state is S_RESYNC.
- S_RESYNC
  - acq_req_o=0. Sample counter, frame_cnt_o and timer are held at 0.
  - Exit to S_WAIT on the first cycle with `time_period_0_10ms_i`=0.
- Resync override: `time_period_0_10ms_i`=1 in any state forces S_RESYNC on the next cycle.
  - acq_req_o drops immediately (registered).
  - An in-flight conversion is abandoned and its done is ignored.
  - No errors are raised by a resync.
- S_WAIT: on `acq_start_pulse_i` -> S_REQ. On that transition, acq_req_o<=1, sample_idx_o<=sample counter, timer<=0.
- S_REQ
  - acq_req_o held high. On `acq_ack_i` -> S_CONV with acq_req_o<=0.
  - A `acq_done_i` seen while still in S_REQ counts as ack+done; go to S_WAIT.
- S_CONV: on `acq_done_i`, sample counter += 1 (saturates at 255), then -> S_WAIT.
- Timer
  - Runs in S_REQ and S_CONV.
  - When timer == ACQ_TIMEOUT-1: set err_timeout_o, acq_req_o<=0, -> S_WAIT. The sample is not counted.
  - A done arriving in that same cycle wins: the sample is counted and no timeout is raised.
- Overrun: `acq_start_pulse_i` in S_REQ or S_CONV sets err_overrun_o. The tick is dropped and not queued.
- Start tick in the same cycle as done: counts as overrun (the FSM is still busy that cycle).
- Frame close: `frame_pulse_i` in S_WAIT, S_REQ or S_CONV triggers all of the following.
  - frame_sample_cnt_o <= sample counter, including a done in the same cycle.
  - frame_done_o pulses; frame_cnt_o += 1 (16-bit wrap).
  - err_count_o set if the closed count != SAMPLES_PER_FRAME.
  - Sample counter <= 0, or 1 if the same-cycle done belongs to... no: the same-cycle done counts toward the closing frame, and the counter clears to 0.
  - An in-flight conversion continues and counts toward the new frame.
- Start tick in the same cycle as frame_pulse_i: it is the first tick of the new frame. Its sample_idx_o is 0.
- `frame_pulse_i` in S_RESYNC is ignored.
- Sticky errors
  - Cleared only by reset or `err_clr_i`. A set in the same cycle as err_clr_i wins.
  - Errors are not cleared by resync.

## Timing
- All outputs are registered. Reset values: every output 0.
- Start tick at cycle N (in S_WAIT) -> acq_req_o=1 at N+1.
- ack at cycle M -> acq_req_o=0 at M+1.
- done at cycle D -> count visible at D+1; S_WAIT at D+1, so a tick at D+1 is accepted.
- frame_pulse_i at cycle F -> frame_done_o, frame_sample_cnt_o, frame_cnt_o and err_count_o all update at F+1.
- Error bits assert 1 cycle after the causing event.
- Resync asserted at cycle R -> acq_req_o=0 and counters=0 at R+1.

## Test plan
- Resync, then 25 ticks at 100_000-cycle spacing, each with ack after 2 cycles and done after 10, then frame_pulse -> frame_sample_cnt_o=25, frame_cnt_o=1, no errors.
- Same stimulus but only 24 ticks -> frame_sample_cnt_o=24, err_count_o=1 at F+1.
- Tick, ack, then no done -> acq_req_o dropped, err_timeout_o=1 exactly ACQ_TIMEOUT cycles after request; the next tick is accepted and counted.
- Second tick 5 cycles after the first while in S_CONV -> err_overrun_o=1 and only one request issued; err_clr_i clears it; err_clr_i together with a new overrun leaves it at 1.
- done and frame_pulse in the same cycle with count at 24 -> frame_sample_cnt_o=25, no err_count_o, next frame starts at 0.
- Assert time_period_0_10ms_i while acq_req_o=1 -> acq_req_o=0 next cycle, frame_cnt_o=0, late done ignored, errors unchanged; after deassert, the next tick gives sample_idx_o=0.

Source files
------------

// File: rtl/acq_frame_sequencer_if.sv
// ADC driver handshake bundle: request/ack/done plus the index of the
// sample being requested.
interface acq_frame_sequencer_if;
  logic       acq_req_o;
  logic [7:0] sample_idx_o;
  logic       acq_ack_i;
  logic       acq_done_i;

  modport master (
    output acq_req_o,
    output sample_idx_o,
    input  acq_ack_i,
    input  acq_done_i
  );

  modport slave (
    input  acq_req_o,
    input  sample_idx_o,
    output acq_ack_i,
    output acq_done_i
  );
endinterface

// File: rtl/acq_frame_sequencer.sv
// Sample-tick to ADC transaction sequencer with per-frame sample
// accounting and sticky overrun/timeout/count faults.
module acq_frame_sequencer #(
  parameter int unsigned SAMPLES_PER_FRAME = 25,
  parameter int unsigned ACQ_TIMEOUT       = 50_000
) (
  input  logic        sys_clk_i,
  input  logic        rst_n_i,
  input  logic        time_period_0_10ms_i,
  input  logic        frame_pulse_i,
  input  logic        acq_start_pulse_i,
  input  logic        err_clr_i,
  acq_frame_sequencer_if.master adc,
  output logic [15:0] frame_cnt_o,
  output logic        frame_done_o,
  output logic [7:0]  frame_sample_cnt_o,
  output logic        err_overrun_o,
  output logic        err_timeout_o,
  output logic        err_count_o
);

  typedef enum logic [1:0] {
    S_RESYNC,
    S_WAIT,
    S_REQ,
    S_CONV
  } state_t;

  localparam logic [19:0] TMO_LAST = 20'(ACQ_TIMEOUT - 1);
  localparam logic [7:0]  SPF      = 8'(SAMPLES_PER_FRAME);

  state_t      r_state;
  state_t      w_state_nxt;
  logic        r_req;
  logic [7:0]  r_idx;
  logic [19:0] r_timer;
  logic [7:0]  r_cnt;
  logic [15:0] r_frames;
  logic        r_fdone;
  logic [7:0]  r_fsc;
  logic        r_err_ovr;
  logic        r_err_tmo;
  logic        r_err_cnt;

  logic        w_busy;
  logic        w_done;
  logic        w_tmo;
  logic        w_issue;
  logic        w_ovr;
  logic        w_close;
  logic [7:0]  w_cnt_nxt;

  always_ff @(posedge sys_clk_i or negedge rst_n_i) begin
    if (!rst_n_i) r_state <= S_RESYNC;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_busy  = (r_state == S_REQ) || (r_state == S_CONV);
    w_done  = w_busy && adc.acq_done_i;
    // a done landing on the last timer cycle beats the timeout
    w_tmo   = w_busy && !adc.acq_done_i && (r_timer == TMO_LAST);
    w_issue = (r_state == S_WAIT) && acq_start_pulse_i;
    w_ovr   = w_busy && acq_start_pulse_i;
    w_close = (r_state != S_RESYNC) && frame_pulse_i;
    unique case (r_state)
      S_RESYNC: w_state_nxt = S_WAIT;
      S_WAIT:   if (w_issue) w_state_nxt = S_REQ;
      S_REQ: begin
        if (w_done || w_tmo)    w_state_nxt = S_WAIT;
        else if (adc.acq_ack_i) w_state_nxt = S_CONV;
      end
      S_CONV:   if (w_done || w_tmo) w_state_nxt = S_WAIT;
      default:  w_state_nxt = S_RESYNC;
    endcase
    // resync window abandons everything and raises nothing
    if (time_period_0_10ms_i) begin
      w_state_nxt = S_RESYNC;
      w_done  = 1'b0;
      w_tmo   = 1'b0;
      w_issue = 1'b0;
      w_ovr   = 1'b0;
      w_close = 1'b0;
    end
    w_cnt_nxt = (w_done && (r_cnt != 8'hFF)) ? r_cnt + 8'd1 : r_cnt;
  end

  always_ff @(posedge sys_clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_req     <= 1'b0;
      r_idx     <= '0;
      r_timer   <= '0;
      r_cnt     <= '0;
      r_frames  <= '0;
      r_fdone   <= 1'b0;
      r_fsc     <= '0;
      r_err_ovr <= 1'b0;
      r_err_tmo <= 1'b0;
      r_err_cnt <= 1'b0;
    end else begin
      r_req   <= (w_state_nxt == S_REQ);
      r_fdone <= w_close;
      if (time_period_0_10ms_i) begin
        r_timer  <= '0;
        r_cnt    <= '0;
        r_frames <= '0;
      end else begin
        if (w_issue) begin
          r_idx   <= w_close ? 8'd0 : r_cnt;
          r_timer <= '0;
        end else if (w_busy) begin
          r_timer <= r_timer + 20'd1;
        end
        r_cnt <= w_close ? 8'd0 : w_cnt_nxt;
        if (w_close) begin
          r_fsc    <= w_cnt_nxt;
          r_frames <= r_frames + 16'd1;
        end
      end
      r_err_ovr <= w_ovr | (r_err_ovr & ~err_clr_i);
      r_err_tmo <= w_tmo | (r_err_tmo & ~err_clr_i);
      r_err_cnt <= (w_close && (w_cnt_nxt != SPF))
                 | (r_err_cnt & ~err_clr_i);
    end
  end

  assign adc.acq_req_o      = r_req;
  assign adc.sample_idx_o   = r_idx;
  assign frame_cnt_o        = r_frames;
  assign frame_done_o       = r_fdone;
  assign frame_sample_cnt_o = r_fsc;
  assign err_overrun_o      = r_err_ovr;
  assign err_timeout_o      = r_err_tmo;
  assign err_count_o        = r_err_cnt;

endmodule
